chopper_out_arb: RTL and testbench
==================================

CHOPPER_OUT_ARB -- requirements
Module: chopper_out_arb

Interface
- REQ-001 shall have parameter DAT_WIDTH, default 64, meaning the data width per source and output, 16/32/64 bits.
- REQ-002 shall have parameter N_SRC, default 4, meaning the number of requesting sources, 2..8.
- REQ-003 shall have parameter TIMEOUT, default 255, meaning the watchdog limit in cycles, 1..65535.
- REQ-004 shall have port Clk, input, 1 bit, the single clock; all logic on its rising edge.
- REQ-005 shall have port Rst, input, 1 bit, reset; synchronous, active-low.
- REQ-006 shall have port Src_Req, input, N_SRC bits, per-source request for one whole packet.
- REQ-007 shall have port Src_Gnt, output, N_SRC bits, one-hot grant, registered.
- REQ-008 shall have ports Src_Val/Src_Sop/Src_Eop/Src_Error, inputs, N_SRC bits each, per-source beat qualifiers.
- REQ-009 shall have port Src_Mod, input, N_SRC*($clog2(DAT_WIDTH/8)+1) bits, packed valid-byte counts.
- REQ-010 shall have port Src_Dat, input, N_SRC*DAT_WIDTH bits, packed data; source i in slice i.
- REQ-011 shall have ports Src_PktLen (N_SRC*16) and Src_PktType (N_SRC*8), inputs, packed packet length and type.
- REQ-012 shall have ports OutBus_Val/Sop/Eop/Error, outputs, 1 bit each, the merged output bus qualifiers.
- REQ-013 shall have ports OutBus_Mod ($clog2(DAT_WIDTH/8)+1), OutBus_Dat (DAT_WIDTH), OutBus_PktLen (16) and OutBus_PktType (8), outputs, the merged output bus fields.
- REQ-014 shall have port Arb_Owner, output, 3 bits, index of the current or last owner.
- REQ-015 shall have port Arb_Busy, output, 1 bit, high while any grant is active.

Function
- REQ-016 shall implement states IDLE, XFER and GAP.
- REQ-017 IDLE: if any Src_Req bit is set, the block shall select a winner round-robin, searching from (Arb_Owner+1) mod N_SRC upward with wrap; set Src_Gnt one-hot, Arb_Owner=winner, Arb_Busy=1; next state XFER.
- REQ-018 grant latency shall be exactly 1 cycle from the Src_Req sample edge to Src_Gnt high.
- REQ-019 XFER: each owner beat with Src_Val=1 shall be registered to OutBus_* one cycle later (Val, Sop, Eop, Mod, Dat, PktLen, PktType, Error copied).
- REQ-020 in cycles without an owner beat, OutBus_Val shall be 0.
- REQ-021 Src_Val from non-owners shall be ignored and shall have no effect on any output.
- REQ-022 XFER: an owner beat with Src_Eop=1 shall clear Src_Gnt and Arb_Busy on the same edge that registers the beat; next state GAP.
- REQ-023 GAP shall last exactly 1 cycle with OutBus_Val=0, then go to IDLE; back-to-back packets therefore have a 1-cycle bubble minimum.
- REQ-024 protocol error: an owner beat with Src_Sop=1 after an earlier Sop in the same grant, without an Eop between them, shall be forwarded with OutBus_Error=1.
- REQ-025 protocol error: a first owner beat in a grant with Src_Sop=0 shall be forwarded with OutBus_Error=1.
- REQ-026 an owner beat with Sop=1 and Eop=1 in the same cycle shall be legal as a single-beat packet.
- REQ-027 dropping Src_Req during XFER shall not release the grant; only Eop or the watchdog (REQ-031) shall release it.
- REQ-028 Src_Req changing in the same cycle as the Eop beat shall be evaluated only in the next IDLE.
- REQ-029 OutBus_Mod shall pass through unmodified; the block shall not check Mod against DAT_WIDTH/8.

Reset
- REQ-030 Rst=0 at a rising edge shall force: state=IDLE; Src_Gnt, Arb_Busy, OutBus_Val/Sop/Eop/Error=0; OutBus_Mod/Dat/PktLen/PktType=0; Arb_Owner=N_SRC-1, so source 0 wins first; watchdog count=0. Reset mid-XFER shall abort the grant with no Eop emitted.

Configuration
- REQ-031 with macro CHOPPER_ARB_WATCHDOG_EN defined: a 16-bit counter shall count consecutive XFER cycles with no owner Val and clear on any owner Val. On reaching TIMEOUT, the block shall emit one beat Val=1, Sop=0, Eop=1, Error=1, Mod=0, Dat=0, release the grant and go to GAP.
- REQ-032 without CHOPPER_ARB_WATCHDOG_EN: no counter shall exist and the grant shall be held until Eop indefinitely.

Verification
- REQ-033 After reset, Src_Req=4'b0101, source 0 sends 3 beats (Sop on beat 1, Eop on beat 3, Mod=8) -> Gnt=0001; three OutBus beats, each 1 cycle after the input beat; GAP; then Gnt=0100.
- REQ-034 All Src_Req=4'b1111 held for 4 packets of 1 beat (Sop+Eop) -> grant order 0,1,2,3; 2-cycle spacing per grant plus a 1-cycle grant latency.
- REQ-035 Owner 2 asserts Sop on beats 1 and 2 -> beat 2 is output with OutBus_Error=1; the grant is held until Eop.
- REQ-036 Source 1 drives Val=1, Dat=0xDEAD while source 0 is owner -> OutBus_Dat never shows 0xDEAD.
- REQ-037 With CHOPPER_ARB_WATCHDOG_EN and TIMEOUT=4, the owner goes silent after Sop -> on the 4th idle cycle the output shows Val=1, Eop=1, Error=1, Mod=0; Gnt=0; Arb_Busy=0.
- REQ-038 Rst=0 asserted mid-packet of source 3 -> next cycle all outputs are 0 and Arb_Owner=N_SRC-1; after release with Src_Req=4'b1000 -> Gnt=1000.

Source files
------------

// File: rtl/chopper_out_arb.sv
// chopper_out_arb: round-robin packet arbiter merging N_SRC beat streams onto
// one registered output bus. A grant covers one whole packet (Sop..Eop),
// followed by a one-cycle gap before the next arbitration.
// Optional: define CHOPPER_ARB_WATCHDOG_EN to add a silent-owner watchdog that
// terminates a stalled packet with an error Eop after TIMEOUT idle cycles.
module chopper_out_arb #(
  parameter int unsigned DAT_WIDTH = 64,
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned MOD_W    = $clog2(DAT_WIDTH / 8) + 1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [N_SRC-1:0]           Src_Req,
  output logic [N_SRC-1:0]           Src_Gnt,
  input  logic [N_SRC-1:0]           Src_Val,
  input  logic [N_SRC-1:0]           Src_Sop,
  input  logic [N_SRC-1:0]           Src_Eop,
  input  logic [N_SRC-1:0]           Src_Error,
  input  logic [N_SRC*MOD_W-1:0]     Src_Mod,
  input  logic [N_SRC*DAT_WIDTH-1:0] Src_Dat,
  input  logic [N_SRC*16-1:0]        Src_PktLen,
  input  logic [N_SRC*8-1:0]         Src_PktType,
  output logic                       OutBus_Val,
  output logic                       OutBus_Sop,
  output logic                       OutBus_Eop,
  output logic                       OutBus_Error,
  output logic [MOD_W-1:0]           OutBus_Mod,
  output logic [DAT_WIDTH-1:0]       OutBus_Dat,
  output logic [15:0]                OutBus_PktLen,
  output logic [7:0]                 OutBus_PktType,
  output logic [2:0]                 Arb_Owner,
  output logic                       Arb_Busy
);

  localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Elaboration-time parameter range guards
  if (N_SRC < 2 || N_SRC > 8) begin : g_bad_nsrc
    $error("chopper_out_arb: N_SRC must be 2..8");
  end
  if (DAT_WIDTH != 16 && DAT_WIDTH != 32 && DAT_WIDTH != 64) begin : g_bad_width
    $error("chopper_out_arb: DAT_WIDTH must be 16, 32 or 64");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("chopper_out_arb: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_GAP = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_owner, w_owner_nxt, w_winner, w_idx;
  logic               w_found;
  logic [N_SRC-1:0]   r_gnt, w_gnt_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_sop_seen, w_sop_seen_nxt;
  logic               r_first, w_first_nxt;
  logic               r_ob_val, r_ob_sop, r_ob_eop, r_ob_err;
  logic               w_ob_val_nxt, w_ob_sop_nxt, w_ob_eop_nxt, w_ob_err_nxt;
  logic [MOD_W-1:0]   r_ob_mod, w_ob_mod_nxt;
  logic [DAT_WIDTH-1:0] r_ob_dat, w_ob_dat_nxt;
  logic [15:0]        r_ob_len, w_ob_len_nxt;
  logic [7:0]         r_ob_typ, w_ob_typ_nxt;
  logic               w_own_val, w_own_sop, w_own_eop, w_own_err;
  logic               w_wd_fire;

  logic [MOD_W-1:0]     w_mod [N_SRC];
  logic [DAT_WIDTH-1:0] w_dat [N_SRC];
  logic [15:0]          w_len [N_SRC];
  logic [7:0]           w_typ [N_SRC];

  // Unpack the per-source payload slices
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
    assign w_mod[gi] = Src_Mod[gi*MOD_W +: MOD_W];
    assign w_dat[gi] = Src_Dat[gi*DAT_WIDTH +: DAT_WIDTH];
    assign w_len[gi] = Src_PktLen[gi*16 +: 16];
    assign w_typ[gi] = Src_PktType[gi*8 +: 8];
  end

  // Owner beat qualifiers; only meaningful while a grant is active
  assign w_own_val = (r_state == S_XFER) && Src_Val[r_owner];
  assign w_own_sop = Src_Sop[r_owner];
  assign w_own_eop = Src_Eop[r_owner];
  assign w_own_err = Src_Error[r_owner];

  // Round-robin search starting one past the last owner
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_owner;
    w_idx    = r_owner;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      w_idx = SEL_W'((32'(r_owner) + k) % N_SRC);
      if (!w_found && Src_Req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef CHOPPER_ARB_WATCHDOG_EN
  logic [15:0] r_wd_cnt, w_wd_cnt_nxt;

  assign w_wd_fire = (r_state == S_XFER) && !w_own_val && (r_wd_cnt == 16'(TIMEOUT - 1));

  // Count consecutive owner-silent XFER cycles
  always_comb begin
    w_wd_cnt_nxt = r_wd_cnt;
    if (r_state != S_XFER || w_own_val || w_wd_fire) w_wd_cnt_nxt = '0;
    else                                             w_wd_cnt_nxt = r_wd_cnt + 16'd1;
  end

  // Watchdog counter register
  always_ff @(posedge Clk) begin
    if (!Rst) r_wd_cnt <= '0;
    else      r_wd_cnt <= w_wd_cnt_nxt;
  end
`else
  assign w_wd_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_XFER;
      S_XFER:  if ((w_own_val && w_own_eop) || w_wd_fire) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of grant, owner tracking and the output bus
  always_comb begin
    w_gnt_nxt      = r_gnt;
    w_owner_nxt    = r_owner;
    w_busy_nxt     = r_busy;
    w_sop_seen_nxt = r_sop_seen;
    w_first_nxt    = r_first;
    w_ob_val_nxt   = 1'b0;
    w_ob_sop_nxt   = 1'b0;
    w_ob_eop_nxt   = 1'b0;
    w_ob_err_nxt   = 1'b0;
    w_ob_mod_nxt   = r_ob_mod;
    w_ob_dat_nxt   = r_ob_dat;
    w_ob_len_nxt   = r_ob_len;
    w_ob_typ_nxt   = r_ob_typ;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt      = N_SRC'(1) << w_winner;
          w_owner_nxt    = w_winner;
          w_busy_nxt     = 1'b1;
          w_sop_seen_nxt = 1'b0;
          w_first_nxt    = 1'b1;
        end
      end
      S_XFER: begin
        if (w_own_val) begin
          w_ob_val_nxt   = 1'b1;
          w_ob_sop_nxt   = w_own_sop;
          w_ob_eop_nxt   = w_own_eop;
          w_ob_err_nxt   = w_own_err | (r_first & ~w_own_sop) | (w_own_sop & r_sop_seen);
          w_ob_mod_nxt   = w_mod[r_owner];
          w_ob_dat_nxt   = w_dat[r_owner];
          w_ob_len_nxt   = w_len[r_owner];
          w_ob_typ_nxt   = w_typ[r_owner];
          w_first_nxt    = 1'b0;
          if (w_own_sop) w_sop_seen_nxt = 1'b1;
          if (w_own_eop) begin
            w_gnt_nxt  = '0;
            w_busy_nxt = 1'b0;
          end
        end else if (w_wd_fire) begin
          w_ob_val_nxt = 1'b1;
          w_ob_eop_nxt = 1'b1;
          w_ob_err_nxt = 1'b1;
          w_ob_mod_nxt = '0;
          w_ob_dat_nxt = '0;
          w_gnt_nxt    = '0;
          w_busy_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and tracking registers
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_gnt      <= '0;
      r_owner    <= SEL_W'(N_SRC - 1);
      r_busy     <= 1'b0;
      r_sop_seen <= 1'b0;
      r_first    <= 1'b0;
      r_ob_val   <= 1'b0;
      r_ob_sop   <= 1'b0;
      r_ob_eop   <= 1'b0;
      r_ob_err   <= 1'b0;
      r_ob_mod   <= '0;
      r_ob_dat   <= '0;
      r_ob_len   <= '0;
      r_ob_typ   <= '0;
    end else begin
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_busy     <= w_busy_nxt;
      r_sop_seen <= w_sop_seen_nxt;
      r_first    <= w_first_nxt;
      r_ob_val   <= w_ob_val_nxt;
      r_ob_sop   <= w_ob_sop_nxt;
      r_ob_eop   <= w_ob_eop_nxt;
      r_ob_err   <= w_ob_err_nxt;
      r_ob_mod   <= w_ob_mod_nxt;
      r_ob_dat   <= w_ob_dat_nxt;
      r_ob_len   <= w_ob_len_nxt;
      r_ob_typ   <= w_ob_typ_nxt;
    end
  end

  assign Src_Gnt        = r_gnt;
  assign Arb_Owner      = 3'(r_owner);
  assign Arb_Busy       = r_busy;
  assign OutBus_Val     = r_ob_val;
  assign OutBus_Sop     = r_ob_sop;
  assign OutBus_Eop     = r_ob_eop;
  assign OutBus_Error   = r_ob_err;
  assign OutBus_Mod     = r_ob_mod;
  assign OutBus_Dat     = r_ob_dat;
  assign OutBus_PktLen  = r_ob_len;
  assign OutBus_PktType = r_ob_typ;

endmodule

// File: tb/tb_chopper_out_arb.sv
// Directed bench for chopper_out_arb with a packet-level reference model.
module tb_chopper_out_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MW = 4;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    Src_Req, Src_Gnt, Src_Val, Src_Sop, Src_Eop, Src_Error;
  logic [N*MW-1:0] Src_Mod;
  logic [N*DW-1:0] Src_Dat;
  logic [N*16-1:0] Src_PktLen;
  logic [N*8-1:0]  Src_PktType;
  logic            OutBus_Val, OutBus_Sop, OutBus_Eop, OutBus_Error;
  logic [MW-1:0]   OutBus_Mod;
  logic [DW-1:0]   OutBus_Dat;
  logic [15:0]     OutBus_PktLen;
  logic [7:0]      OutBus_PktType;
  logic [2:0]      Arb_Owner;
  logic            Arb_Busy;

  chopper_out_arb #(.DAT_WIDTH(DW), .N_SRC(N), .TIMEOUT(TO)) dut (
    .Clk(clk), .Rst(Rst),
    .Src_Req(Src_Req), .Src_Gnt(Src_Gnt),
    .Src_Val(Src_Val), .Src_Sop(Src_Sop), .Src_Eop(Src_Eop), .Src_Error(Src_Error),
    .Src_Mod(Src_Mod), .Src_Dat(Src_Dat), .Src_PktLen(Src_PktLen), .Src_PktType(Src_PktType),
    .OutBus_Val(OutBus_Val), .OutBus_Sop(OutBus_Sop), .OutBus_Eop(OutBus_Eop),
    .OutBus_Error(OutBus_Error), .OutBus_Mod(OutBus_Mod), .OutBus_Dat(OutBus_Dat),
    .OutBus_PktLen(OutBus_PktLen), .OutBus_PktType(OutBus_PktType),
    .Arb_Owner(Arb_Owner), .Arb_Busy(Arb_Busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (packet-level) ----------------
  int          m_phase;   // 0 idle, 1 owning a packet, 2 gap
  logic [1:0]  m_owner;
  logic [3:0]  m_gnt;
  logic        m_busy, m_val, m_sop, m_eop, m_err;
  logic [MW-1:0] m_mod;
  logic [DW-1:0] m_dat;
  logic [15:0] m_len;
  logic [7:0]  m_typ;
  int          m_beats, m_sops, m_idle;
  bit          m_ready = 1'b0;

  function automatic int rr_pick(input int o, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (((req >> ((o + k) % N)) & 4'd1) != 4'd0) return (o + k) % N;
    return o;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    return 4'(1) << i;
  endfunction

  function automatic logic [DW-1:0] dat_of(input int s);
    return Src_Dat[s*DW +: DW];
  endfunction
  function automatic logic [MW-1:0] mod_of(input int s);
    return Src_Mod[s*MW +: MW];
  endfunction
  function automatic logic [15:0] len_of(input int s);
    return Src_PktLen[s*16 +: 16];
  endfunction
  function automatic logic [7:0] typ_of(input int s);
    return Src_PktType[s*8 +: 8];
  endfunction

  always @(posedge clk) begin
    if (!Rst) begin
      m_phase <= 0; m_owner <= 2'(N - 1); m_gnt <= '0; m_busy <= 1'b0;
      m_val <= 1'b0; m_sop <= 1'b0; m_eop <= 1'b0; m_err <= 1'b0;
      m_mod <= '0; m_dat <= '0; m_len <= '0; m_typ <= '0;
      m_beats <= 0; m_sops <= 0; m_idle <= 0; m_ready <= 1'b1;
    end else begin
      m_val <= 1'b0; m_sop <= 1'b0; m_eop <= 1'b0; m_err <= 1'b0;
      case (m_phase)
        0: if (Src_Req != '0) begin
          m_owner <= 2'(rr_pick(int'(m_owner), Src_Req));
          m_gnt   <= onehot(rr_pick(int'(m_owner), Src_Req));
          m_busy  <= 1'b1; m_phase <= 1;
          m_beats <= 0; m_sops <= 0; m_idle <= 0;
        end
        1: if (Src_Val[m_owner]) begin
          m_val <= 1'b1;
          m_sop <= Src_Sop[m_owner];
          m_eop <= Src_Eop[m_owner];
          m_err <= Src_Error[m_owner] || (m_beats == 0 && !Src_Sop[m_owner])
                   || (Src_Sop[m_owner] && m_sops > 0);
          m_mod <= mod_of(int'(m_owner)); m_dat <= dat_of(int'(m_owner));
          m_len <= len_of(int'(m_owner)); m_typ <= typ_of(int'(m_owner));
          m_beats <= m_beats + 1;
          if (Src_Sop[m_owner]) m_sops <= m_sops + 1;
          m_idle <= 0;
          if (Src_Eop[m_owner]) begin m_gnt <= '0; m_busy <= 1'b0; m_phase <= 2; end
        end else begin
          m_idle <= m_idle + 1;
`ifdef CHOPPER_ARB_WATCHDOG_EN
          if (m_idle + 1 == TO) begin
            m_val <= 1'b1; m_eop <= 1'b1; m_err <= 1'b1; m_mod <= '0; m_dat <= '0;
            m_gnt <= '0; m_busy <= 1'b0; m_phase <= 2; m_idle <= 0;
          end
`endif
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ready) begin
      chk("m_gnt",   64'(Src_Gnt),      64'(m_gnt));
      chk("m_owner", 64'(Arb_Owner),    64'(m_owner));
      chk("m_busy",  64'(Arb_Busy),     64'(m_busy));
      chk("m_val",   64'(OutBus_Val),   64'(m_val));
      chk("m_sop",   64'(OutBus_Sop),   64'(m_sop));
      chk("m_eop",   64'(OutBus_Eop),   64'(m_eop));
      chk("m_err",   64'(OutBus_Error), 64'(m_err));
      if (m_val) begin
        chk("m_mod", 64'(OutBus_Mod),     64'(m_mod));
        chk("m_dat", 64'(OutBus_Dat),     64'(m_dat));
        chk("m_len", 64'(OutBus_PktLen),  64'(m_len));
        chk("m_typ", 64'(OutBus_PktType), 64'(m_typ));
      end
      chk("no_dead", 64'(OutBus_Dat == 64'hDEAD), 64'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_beat(input int s, input logic sop, input logic eop, input logic err,
                            input logic [MW-1:0] mod, input logic [DW-1:0] dat);
    Src_Val[s] = 1'b1; Src_Sop[s] = sop; Src_Eop[s] = eop; Src_Error[s] = err;
    Src_Mod[s*MW +: MW] = mod;
    Src_Dat[s*DW +: DW] = dat;
  endtask

  task automatic clr_beats();
    Src_Val = '0; Src_Sop = '0; Src_Eop = '0; Src_Error = '0;
  endtask

  task automatic wait_gnt(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Src_Gnt != '0) begin ok = 1'b1; break; end
      tick();
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  int last_cyc;

  initial begin
    Rst = 1'b0; Src_Req = '0; clr_beats(); Src_Mod = '0; Src_Dat = '0;
    for (int s = 0; s < N; s++) begin
      Src_PktLen[s*16 +: 16] = 16'(100 + s * 10);
      Src_PktType[s*8 +: 8]  = 8'(8'hA0 + s);
    end
    tick(); tick();
    chk("rst_gnt",   64'(Src_Gnt),    64'd0);
    chk("rst_owner", 64'(Arb_Owner),  64'd3);
    chk("rst_busy",  64'(Arb_Busy),   64'd0);
    chk("rst_val",   64'(OutBus_Val), 64'd0);
    chk("rst_dat",   64'(OutBus_Dat), 64'd0);
    Rst = 1'b1;

    // All requesting, single-beat packets: order 0,1,2,3 every 3 cycles
    Src_Req = 4'b1111;
    last_cyc = 0;
    for (int p = 0; p < 4; p++) begin
      wait_gnt("rr_wait");
      chk("rr_gnt", 64'(Src_Gnt), 64'(onehot(p)));
      if (p > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd3);
      last_cyc = cyc;
      drive_beat(p, 1'b1, 1'b1, 1'b0, 4'd8, 64'(p + 256));
      tick();
      clr_beats();
    end

    // Source 0 three-beat packet, source 1 chatters with 0xDEAD
    Src_Req = 4'b0101;
    drive_beat(1, 1'b1, 1'b1, 1'b0, 4'd8, 64'hDEAD);
    wait_gnt("a_wait");
    chk("a_gnt",   64'(Src_Gnt),   64'b0001);
    chk("a_owner", 64'(Arb_Owner), 64'd0);
    chk("a_busy",  64'(Arb_Busy),  64'd1);
    drive_beat(0, 1'b1, 1'b0, 1'b0, 4'd8, 64'h1111);
    tick();
    chk("a_b1_sop", 64'(OutBus_Sop), 64'd1);
    chk("a_b1_dat", OutBus_Dat,      64'h1111);
    chk("a_b1_mod", 64'(OutBus_Mod), 64'd8);
    chk("a_b1_len", 64'(OutBus_PktLen), 64'd100);
    drive_beat(0, 1'b0, 1'b0, 1'b1, 4'd8, 64'h2222);
    tick();
    chk("a_b2_dat", OutBus_Dat,        64'h2222);
    chk("a_b2_err", 64'(OutBus_Error), 64'd1);
    drive_beat(0, 1'b0, 1'b1, 1'b0, 4'd8, 64'h3333);
    tick();
    chk("a_b3_eop",  64'(OutBus_Eop), 64'd1);
    chk("a_b3_dat",  OutBus_Dat,      64'h3333);
    chk("a_rel_gnt", 64'(Src_Gnt),    64'd0);
    clr_beats();
    tick();
    chk("a_gap_val", 64'(OutBus_Val), 64'd0);
    chk("a_gap_gnt", 64'(Src_Gnt),    64'd0);
    tick();
    chk("a_next_gnt", 64'(Src_Gnt), 64'b0100);

    // Owner 2: repeated Sop flags an error; dropping Req keeps the grant
    Src_Req = '0;
    drive_beat(2, 1'b1, 1'b0, 1'b0, 4'd8, 64'h4444);
    tick();
    chk("b_b1_err", 64'(OutBus_Error), 64'd0);
    drive_beat(2, 1'b1, 1'b0, 1'b0, 4'd8, 64'h5555);
    tick();
    chk("b_b2_err", 64'(OutBus_Error), 64'd1);
    chk("b_hold",   64'(Src_Gnt),      64'b0100);
    clr_beats();
    tick();
    chk("b_idle_val",  64'(OutBus_Val), 64'd0);
    chk("b_idle_hold", 64'(Src_Gnt),    64'b0100);
    drive_beat(2, 1'b0, 1'b1, 1'b0, 4'd3, 64'h6666);
    tick();
    chk("b_eop_err", 64'(OutBus_Error), 64'd0);
    chk("b_eop_mod", 64'(OutBus_Mod),   64'd3);
    chk("b_rel",     64'(Src_Gnt),      64'd0);
    clr_beats();

    // Source 3 aborted by reset mid-packet
    Src_Req = 4'b1000;
    wait_gnt("e_wait");
    chk("e_gnt", 64'(Src_Gnt), 64'b1000);
    drive_beat(3, 1'b1, 1'b0, 1'b0, 4'd8, 64'h7777);
    tick();
    chk("e_b1_val", 64'(OutBus_Val), 64'd1);
    drive_beat(3, 1'b0, 1'b0, 1'b0, 4'd8, 64'h8888);
    Rst = 1'b0;
    tick();
    chk("e_rst_gnt",   64'(Src_Gnt),        64'd0);
    chk("e_rst_busy",  64'(Arb_Busy),       64'd0);
    chk("e_rst_owner", 64'(Arb_Owner),      64'd3);
    chk("e_rst_val",   64'(OutBus_Val),     64'd0);
    chk("e_rst_eop",   64'(OutBus_Eop),     64'd0);
    chk("e_rst_dat",   OutBus_Dat,          64'd0);
    chk("e_rst_len",   64'(OutBus_PktLen),  64'd0);
    chk("e_rst_typ",   64'(OutBus_PktType), 64'd0);
    Rst = 1'b1;
    clr_beats();
    tick();
    chk("e_regnt", 64'(Src_Gnt), 64'b1000);
    // First beat lacking Sop is forwarded with error
    Src_Req = '0;
    drive_beat(3, 1'b0, 1'b1, 1'b0, 4'd8, 64'h9999);
    tick();
    chk("e_nosop_err", 64'(OutBus_Error), 64'd1);
    chk("e_nosop_eop", 64'(OutBus_Eop),   64'd1);
    chk("e_nosop_typ", 64'(OutBus_PktType), 64'hA3);
    clr_beats();

    // Silent owner after Sop
    Src_Req = 4'b0001;
    wait_gnt("w_wait");
    chk("w_gnt", 64'(Src_Gnt), 64'b0001);
    drive_beat(0, 1'b1, 1'b0, 1'b0, 4'd8, 64'hAAAA);
    tick();
    clr_beats();
    Src_Req = '0;
`ifdef CHOPPER_ARB_WATCHDOG_EN
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("w_hold", 64'(Src_Gnt), 64'b0001);
    end
    tick();
    chk("w_val",  64'(OutBus_Val),   64'd1);
    chk("w_sop",  64'(OutBus_Sop),   64'd0);
    chk("w_eop",  64'(OutBus_Eop),   64'd1);
    chk("w_err",  64'(OutBus_Error), 64'd1);
    chk("w_mod",  64'(OutBus_Mod),   64'd0);
    chk("w_dat",  OutBus_Dat,        64'd0);
    chk("w_gnt0", 64'(Src_Gnt),      64'd0);
    chk("w_busy", 64'(Arb_Busy),     64'd0);
`else
    repeat (20) tick();
    chk("w_nowd_gnt",  64'(Src_Gnt),  64'b0001);
    chk("w_nowd_busy", 64'(Arb_Busy), 64'd1);
    drive_beat(0, 1'b0, 1'b1, 1'b0, 4'd8, 64'hBBBB);
    tick();
    chk("w_nowd_eop", 64'(OutBus_Eop), 64'd1);
    clr_beats();
`endif
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
